// File: rtl/mem_config_pkg.sv
// Shared types and defaults for the ping-pong frame buffer.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package mem_config_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  // Ownership lifecycle of one bank: written by the source, then consumed by the reader.
  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_e;

  // The writer may target a bank that is empty or part-way through a frame.
  function automatic logic bank_writable(input bank_state_e s);
    return (s == FREE) || (s == FILLING);
  endfunction

  // The reader may target a bank that holds a complete frame.
  function automatic logic bank_readable(input bank_state_e s);
    return (s == FULL) || (s == READING);
  endfunction

endpackage

// File: rtl/dp_bram_bank.sv
// Simple dual-port block RAM: one write port, one synchronous read port, same clock.
// Latency: read data registered, valid the cycle after i_rd_en; holds until the next read.
// Backpressure: none; accepts a write and a read every cycle.
// Ports: i_clk; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_en/i_rd_addr read request; o_rd_data.
module dp_bram_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // No reset on the array or the read register so the tools can map this onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Two-bank ping-pong frame buffer: writer fills one bank while the reader drains the other.
// Latency: read data valid 1+OUT_REG cycles after an accepted read; fully pipelined.
// Backpressure: wr_ready_o low while both banks hold frames; rd_ready_o low until a frame is complete.
// Ports: clk_i/rst_i (async, active-high); wr_valid_i/wr_ready_o/wr_addr_i/wr_data_i/wr_last_i write side;
//  rd_valid_i/rd_ready_o/rd_addr_i/rd_done_i read side; rd_data_valid_o/rd_data_o read return;
//  frame_cnt_o banks holding frames (0..2); err_o sticky release-without-frame flag.
module pingpong_frame_buffer
  import mem_config_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_done_i,
  output logic                  rd_data_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [1:0]            frame_cnt_o,
  output logic                  err_o
);

  // Bank ownership state and pointers
  bank_state_e r_state [2];
  bank_state_e w_state_nxt [2];
  logic        r_wr_bank;
  logic        r_rd_bank;
  logic [1:0]  r_frame_cnt;
  logic        r_err;

  logic        w_wr_ready;
  logic        w_rd_ready;
  logic        w_wr_acc;
  logic        w_rd_acc;
  logic        w_release;
  logic        w_err_set;
  logic [1:0]  w_frame_cnt_nxt;

  assign w_wr_ready = bank_writable(r_state[r_wr_bank]);
  assign w_rd_ready = bank_readable(r_state[r_rd_bank]);
  assign w_wr_acc   = wr_valid_i & w_wr_ready;
  assign w_rd_acc   = rd_valid_i & w_rd_ready;
  // A release only counts when the reader actually owns a frame; otherwise it is flagged.
  assign w_release  = rd_done_i & w_rd_ready;
  assign w_err_set  = rd_done_i & ~w_rd_ready;

  // The write bank is always FREE/FILLING and the read bank FULL/READING, so when both sides
  // act in the same cycle they necessarily touch different banks and both updates apply.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_wr_acc && (r_wr_bank == b[0])) begin
        w_state_nxt[b] = wr_last_i ? FULL : FILLING;
      end
      if (r_rd_bank == b[0]) begin
        if (w_release) begin
          w_state_nxt[b] = FREE;
        end else if (w_rd_acc && (r_state[b] == FULL)) begin
          w_state_nxt[b] = READING;
        end
      end
    end
    w_frame_cnt_nxt = 2'(bank_readable(w_state_nxt[0])) + 2'(bank_readable(w_state_nxt[1]));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state[0]  <= FREE;
      r_state[1]  <= FREE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= 2'd0;
      r_err       <= 1'b0;
    end else begin
      r_state[0]  <= w_state_nxt[0];
      r_state[1]  <= w_state_nxt[1];
      r_wr_bank   <= r_wr_bank ^ (w_wr_acc & wr_last_i);
      r_rd_bank   <= r_rd_bank ^ w_release;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_err       <= r_err | w_err_set;
    end
  end

  // RAM banks
  logic [DATA_WIDTH-1:0] w_bank_q [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    dp_bram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .i_clk    (clk_i),
      .i_wr_en  (w_wr_acc & (r_wr_bank == 1'(g))),
      .i_wr_addr(wr_addr_i),
      .i_wr_data(wr_data_i),
      .i_rd_en  (w_rd_acc & (r_rd_bank == 1'(g))),
      .i_rd_addr(rd_addr_i),
      .o_rd_data(w_bank_q[g])
    );
  end

  // Read return pipeline. r_rd_sel remembers which bank served the most recent read; it only
  // moves on an accepted read so the mux output holds between reads even after rd_bank swaps.
  logic                  r_rd_vld1;
  logic                  r_rd_sel;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_vld1 <= 1'b0;
      r_rd_sel  <= 1'b0;
    end else begin
      r_rd_vld1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_sel <= r_rd_bank;
      end
    end
  end

  assign w_rd_mux = w_bank_q[r_rd_sel];

  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_rd_vld2;
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_rd_vld2 <= 1'b0;
        r_rd_data <= '0;
      end else begin
        r_rd_vld2 <= r_rd_vld1;
        if (r_rd_vld1) begin
          r_rd_data <= w_rd_mux;
        end
      end
    end

    assign rd_data_valid_o = r_rd_vld2;
    assign rd_data_o       = r_rd_data;
  end else begin : g_no_out_reg
    // RAM read registers are not reset; mask them to zero until the first read lands.
    logic r_seen;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_seen <= 1'b0;
      end else begin
        r_seen <= r_seen | w_rd_acc;
      end
    end

    assign rd_data_valid_o = r_rd_vld1;
    assign rd_data_o       = r_seen ? w_rd_mux : '0;
  end

  assign wr_ready_o  = w_wr_ready;
  assign rd_ready_o  = w_rd_ready;
  assign frame_cnt_o = r_frame_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for the ping-pong frame buffer.
// Latency: checks read return at 1+OUT_REG cycles per accepted read.
// Backpressure: exercises both-banks-full stall and release.
module tb_pingpong_frame_buffer;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int OR = 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_last_i;
  logic          rd_valid_i;
  logic          rd_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic          rd_done_i;
  logic          rd_data_valid_o;
  logic [DW-1:0] rd_data_o;
  logic [1:0]    frame_cnt_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  pingpong_frame_buffer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .OUT_REG   (OR)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .wr_last_i      (wr_last_i),
    .rd_valid_i     (rd_valid_i),
    .rd_ready_o     (rd_ready_o),
    .rd_addr_i      (rd_addr_i),
    .rd_done_i      (rd_done_i),
    .rd_data_valid_o(rd_data_valid_o),
    .rd_data_o      (rd_data_o),
    .frame_cnt_o    (frame_cnt_o),
    .err_o          (err_o)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected and observed read returns (data and the cycle they appear in)
  logic [DW-1:0] exp_d_q [$];
  int            exp_c_q [$];
  logic [DW-1:0] got_d_q [$];
  int            got_c_q [$];
  bit            mon_en   = 1'b1;
  int            post_vld = 0;

  always @(negedge clk_i) begin
    if (rd_data_valid_o === 1'b1) begin
      if (mon_en) begin
        got_d_q.push_back(rd_data_o);
        got_c_q.push_back(cyc);
      end else begin
        post_vld++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One cycle of stimulus; inputs return to idle afterwards.
  task automatic step(input int wv, input int wa, input int wd, input int wl,
                      input int rv, input int ra, input int exp_d, input int dn);
    wr_valid_i = 1'(wv);
    wr_addr_i  = AW'(wa);
    wr_data_i  = DW'(wd);
    wr_last_i  = 1'(wl);
    rd_valid_i = 1'(rv);
    rd_addr_i  = AW'(ra);
    rd_done_i  = 1'(dn);
    if (rv != 0) begin
      exp_d_q.push_back(DW'(exp_d));
      exp_c_q.push_back(cyc + 1 + OR);
    end
    tick();
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
    rd_valid_i = 1'b0;
    rd_done_i  = 1'b0;
  endtask

  task automatic write_frame(input int n, input int base);
    for (int i = 0; i < n; i++) step(1, i, base + i, int'(i == n - 1), 0, 0, 0, 0);
  endtask

  task automatic read_frame(input int n, input int base, input int done_last);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 1, i, base + i, int'((done_last != 0) && (i == n - 1)));
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    chk({tag, " count"}, got_d_q.size(), exp_d_q.size());
    while (exp_d_q.size() > 0 && got_d_q.size() > 0) begin
      chk({tag, " data"}, int'(got_d_q.pop_front()), int'(exp_d_q.pop_front()));
      chk({tag, " cycle"}, got_c_q.pop_front(), exp_c_q.pop_front());
    end
    exp_d_q.delete();
    exp_c_q.delete();
    got_d_q.delete();
    got_c_q.delete();
  endtask

  initial begin
    rst_i      = 1'b1;
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    wr_last_i  = 1'b0;
    rd_valid_i = 1'b0;
    rd_addr_i  = '0;
    rd_done_i  = 1'b0;
    repeat (3) tick();

    // 1: reset and idle
    chk("rst wr_ready", int'(wr_ready_o), 1);
    chk("rst rd_ready", int'(rd_ready_o), 0);
    chk("rst frame_cnt", int'(frame_cnt_o), 0);
    chk("rst err", int'(err_o), 0);
    chk("rst rd_vld", int'(rd_data_valid_o), 0);
    chk("rst rd_data", int'(rd_data_o), 0);
    rst_i = 1'b0;
    tick();
    chk("idle wr_ready", int'(wr_ready_o), 1);
    chk("idle rd_ready", int'(rd_ready_o), 0);

    // 2: one 16-pixel frame into bank0, read back-to-back
    write_frame(16, 0);
    chk("t2 frame_cnt", int'(frame_cnt_o), 1);
    chk("t2 rd_ready", int'(rd_ready_o), 1);
    chk("t2 wr_ready", int'(wr_ready_o), 1);
    read_frame(16, 0, 0);
    chk("t2 frame_cnt reading", int'(frame_cnt_o), 1);
    drain("t2");

    // 3: fill bank1 too -> writer stalls; write while stalled is dropped; release frees bank0
    write_frame(16, 8'h80);
    chk("t3 wr_ready full", int'(wr_ready_o), 0);
    chk("t3 frame_cnt full", int'(frame_cnt_o), 2);
    step(1, 0, 8'hFF, 1, 0, 0, 0, 0);
    chk("t3 stalled frame_cnt", int'(frame_cnt_o), 2);
    chk("t3 stalled wr_ready", int'(wr_ready_o), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t3 wr_ready after done", int'(wr_ready_o), 1);
    chk("t3 frame_cnt after done", int'(frame_cnt_o), 1);
    chk("t3 rd_ready bank1", int'(rd_ready_o), 1);
    read_frame(16, 8'h80, 0);
    drain("t3");

    // 4: write next frame into bank0 while reading bank1; last and done coincide
    for (int i = 0; i < 16; i++) begin
      step(1, i, 8'h40 + i, int'(i == 15), 1, i, 8'h80 + i, int'(i == 15));
      if (i == 8) chk("t4 frame_cnt mid", int'(frame_cnt_o), 1);
    end
    chk("t4 frame_cnt end", int'(frame_cnt_o), 1);
    chk("t4 rd_ready", int'(rd_ready_o), 1);
    chk("t4 wr_ready", int'(wr_ready_o), 1);
    drain("t4 concurrent");
    read_frame(16, 8'h40, 1);
    chk("t4 frame_cnt drained", int'(frame_cnt_o), 0);
    chk("t4 rd_ready drained", int'(rd_ready_o), 0);
    drain("t4 bank0");

    // 5: release with nothing readable
    chk("t5 err before", int'(err_o), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5 err set", int'(err_o), 1);
    chk("t5 frame_cnt", int'(frame_cnt_o), 0);
    chk("t5 wr_ready", int'(wr_ready_o), 1);
    chk("t5 rd_ready", int'(rd_ready_o), 0);
    tick();
    chk("t5 err sticky", int'(err_o), 1);

    // 6: reset with reads in flight
    write_frame(4, 8'h10);
    chk("t6 rd_ready", int'(rd_ready_o), 1);
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, i, 8'h10 + i, 0);
    rst_i = 1'b1;
    #1;
    post_vld = 0;
    chk("t6 rd_vld in reset", int'(rd_data_valid_o), 0);
    chk("t6 rd_data in reset", int'(rd_data_o), 0);
    chk("t6 frame_cnt in reset", int'(frame_cnt_o), 0);
    chk("t6 err cleared", int'(err_o), 0);
    chk("t6 rd_ready in reset", int'(rd_ready_o), 0);
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (6) tick();
    chk("t6 late valid pulses", post_vld, 0);
    exp_d_q.delete();
    exp_c_q.delete();
    mon_en = 1'b1;

    // 7: single-pixel frame (FREE -> FULL) and read with done on the same cycle
    step(1, 5, 8'hA5, 1, 0, 0, 0, 0);
    chk("t7 frame_cnt", int'(frame_cnt_o), 1);
    step(0, 0, 0, 0, 1, 5, 8'hA5, 1);
    chk("t7 frame_cnt released", int'(frame_cnt_o), 0);
    drain("t7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
